// File: rtl/alu_batch_sequencer.sv
// Batch ALU engine: walks addresses 0..DEPTH-1 of the A/B/op memories,
// evaluates one operation per element and writes it to the result memory (3 cycles/element).
module alu_batch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 3,
  parameter int DEPTH      = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] addr_rd_o,
  output logic                  en_rd_o,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  output logic [ADDR_WIDTH-1:0] addr_wr_o,
  output logic                  en_wr_o,
  output logic                  we_wr_o,
  output logic [DATA_WIDTH-1:0] data_wr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  // Memory handshake: en_rd_o high for one cycle with addr_rd_o presents a read;
  // data_a_i/data_b_i/op_i are valid the following cycle. en_wr_o/we_wr_o high for
  // one cycle with addr_wr_o/data_wr_o commits a write on the closing clock edge.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  start_q;
  logic                  armed;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [SH_W-1:0]       sh_amt;

  assign state_o = state;
  assign sh_amt  = data_b_i[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op_i)
      3'd0:    alu_res = data_a_i + data_b_i;
      3'd1:    alu_res = data_a_i - data_b_i;
      3'd2:    alu_res = data_a_i & data_b_i;
      3'd3:    alu_res = data_a_i | data_b_i;
      3'd4:    alu_res = data_a_i << sh_amt;
      3'd5:    alu_res = data_a_i >> sh_amt;
      3'd6:    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(data_a_i) < $signed(data_b_i))};
      default: alu_res = data_a_i ^ data_b_i;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= '0;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      addr_rd_o <= '0;
      en_rd_o   <= 1'b0;
      addr_wr_o <= '0;
      en_wr_o   <= 1'b0;
      we_wr_o   <= 1'b0;
      data_wr_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      start_q <= start_i;
      // A start level held across reset release must be seen low once before it can launch.
      armed   <= armed | ~start_i;
      en_rd_o <= 1'b0;
      en_wr_o <= 1'b0;
      we_wr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !start_q && armed) begin
            state     <= READ;
            idx       <= '0;
            busy_o    <= 1'b1;
            en_rd_o   <= 1'b1;
            addr_rd_o <= '0;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          data_wr_o <= alu_res;
          addr_wr_o <= idx;
          en_wr_o   <= 1'b1;
          we_wr_o   <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            idx       <= idx + 1'b1;
            addr_rd_o <= idx + 1'b1;
            en_rd_o   <= 1'b1;
            state     <= READ;
          end
        end
        DONE: begin
          if (!start_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_batch_sequencer.sv
// Bench for alu_batch_sequencer: BRAM models around the engine, a behavioural ALU
// reference feeding an expected-result queue, and cycle-exact protocol checks.
module tb_alu_batch_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int OW    = 3;
  localparam int DEPTH = 1024;

  logic          CLK;
  logic          RST;
  logic          start_i;
  logic [AW-1:0] addr_rd_o;
  logic          en_rd_o;
  logic [DW-1:0] data_a_i;
  logic [DW-1:0] data_b_i;
  logic [OW-1:0] op_i;
  logic [AW-1:0] addr_wr_o;
  logic          en_wr_o;
  logic          we_wr_o;
  logic [DW-1:0] data_wr_o;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    state_o;

  logic [DW-1:0] mem_a   [DEPTH];
  logic [DW-1:0] mem_b   [DEPTH];
  logic [OW-1:0] mem_op  [DEPTH];
  logic [DW-1:0] res_mem [DEPTH];
  logic [DW-1:0] exp_q[$];

  int n_cmp;
  int n_err;

  alu_batch_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i),
    .addr_rd_o(addr_rd_o), .en_rd_o(en_rd_o),
    .data_a_i(data_a_i), .data_b_i(data_b_i), .op_i(op_i),
    .addr_wr_o(addr_wr_o), .en_wr_o(en_wr_o), .we_wr_o(we_wr_o),
    .data_wr_o(data_wr_o), .busy_o(busy_o), .done_o(done_o),
    .state_o(state_o)
  );

  // clock / memories
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (en_rd_o) begin
      data_a_i <= mem_a[addr_rd_o];
      data_b_i <= mem_b[addr_rd_o];
      op_i     <= mem_op[addr_rd_o];
    end
    if (en_wr_o && we_wr_o) res_mem[addr_wr_o] <= data_wr_o;
  end

  // reference ALU from the opcode table
  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
    int unsigned sh;
    int sa;
    int sb;
    sh = b % DW;
    sa = a;
    sb = b;
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a << sh;
      5:       return a >> sh;
      6:       return (sa < sb) ? 1 : 0;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_alu(mem_a[i], mem_b[i], mem_op[i]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":en_rd"}, en_rd_o, 0);
    check({tag, ":en_wr"}, en_wr_o, 0);
    check({tag, ":we_wr"}, we_wr_o, 0);
    check({tag, ":addr_rd"}, addr_rd_o, 0);
    check({tag, ":addr_wr"}, addr_wr_o, 0);
    check({tag, ":data_wr"}, data_wr_o, 0);
    check({tag, ":busy"}, busy_o, 0);
    check({tag, ":done"}, done_o, 0);
  endtask

  // Launch a run and check every cycle up to the first cycle with done_o expected.
  task automatic do_run(input string tag, input bit toggle_mid);
    int writes;
    writes = 0;
    @(negedge CLK);
    start_i = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 3*DEPTH+1; cyc++) begin
      @(negedge CLK);
      check({tag, ":overlap"}, en_rd_o & en_wr_o, 0);
      check({tag, ":busy"}, busy_o, cyc <= 3*DEPTH);
      check({tag, ":done"}, done_o, cyc == 3*DEPTH+1);
      check({tag, ":en_rd"}, en_rd_o, (cyc % 3 == 1) && (cyc <= 3*DEPTH));
      if (en_rd_o) check({tag, ":addr_rd"}, addr_rd_o, (cyc - 1) / 3);
      check({tag, ":en_wr"}, en_wr_o, cyc % 3 == 0);
      if (en_wr_o) begin
        check({tag, ":we_wr"}, we_wr_o, 1);
        check({tag, ":addr_wr"}, addr_wr_o, writes);
        if (exp_q.size() > 0) check({tag, ":data_wr"}, data_wr_o, exp_q.pop_front());
        writes++;
      end
      if (toggle_mid && cyc == 500) start_i = 1'b0;
      if (toggle_mid && cyc == 503) start_i = 1'b1;
    end
    check({tag, ":write_count"}, writes, DEPTH);
    check({tag, ":exp_left"}, exp_q.size(), 0);
  endtask

  // Hold start high after done, then drop it.
  task automatic done_handshake(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check({tag, ":hold_done"}, done_o, 1);
      check({tag, ":hold_busy"}, busy_o, 0);
      check({tag, ":hold_en_rd"}, en_rd_o, 0);
      check({tag, ":hold_en_wr"}, en_wr_o, 0);
    end
    start_i = 1'b0;
    @(negedge CLK);
    check({tag, ":done_drop"}, done_o, 0);
    @(negedge CLK);
    check({tag, ":idle_busy"}, busy_o, 0);
  endtask

  logic [DW-1:0] pat [8];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    start_i = 1'b0;
    data_a_i = '0;
    data_b_i = '0;
    op_i     = '0;
    pat[0] = 32'h6;  pat[1] = 32'hFFFF_FFFC; pat[2] = 32'h1;  pat[3] = 32'h5;
    pat[4] = 32'h20; pat[5] = 32'h0;         pat[6] = 32'h1;  pat[7] = 32'h4;

    // reset
    RST = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_reset:busy", busy_o, 0);

    // run 1: A=1, B=5, op=i%8
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h1; mem_b[i] = 32'h5; mem_op[i] = OW'(i % 8);
    end
    fill_exp();
    do_run("pattern", 1'b0);
    @(negedge CLK);
    for (int i = 0; i < 8; i++) check($sformatf("pattern_res%0d", i), res_mem[i], pat[i]);
    check("pattern_res1023", res_mem[1023], pat[7]);
    done_handshake("pattern");

    // run 2: random data with boundary operands embedded, start toggled mid-run
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom; mem_b[i] = $urandom; mem_op[i] = OW'($urandom_range(0, 7));
    end
    mem_a[10] = 32'hFFFF_FFFF; mem_b[10] = 32'h1;  mem_op[10] = 3'd0;
    mem_a[11] = 32'hFFFF_FFFF; mem_b[11] = 32'h1;  mem_op[11] = 3'd6;
    mem_a[12] = 32'hFFFF_FFFF; mem_b[12] = 32'h1;  mem_op[12] = 3'd5;
    mem_a[13] = 32'h1;         mem_b[13] = 32'h25; mem_op[13] = 3'd4;
    mem_a[14] = 32'h8000_0000; mem_b[14] = 32'h1;  mem_op[14] = 3'd6;
    fill_exp();
    do_run("random", 1'b1);
    @(negedge CLK);
    check("bound_add", res_mem[10], 32'h0);
    check("bound_slt", res_mem[11], 32'h1);
    check("bound_srl", res_mem[12], 32'h7FFF_FFFF);
    check("bound_sll", res_mem[13], 32'h20);
    check("bound_slt_min", res_mem[14], 32'h1);
    done_handshake("random");

    // run 3: identical second run after the handshake
    fill_exp();
    do_run("rerun", 1'b0);
    done_handshake("rerun");

    // reset in the middle of a run, at element 100
    fill_exp();
    @(negedge CLK);
    start_i = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 301; cyc++) @(negedge CLK);
    check("mid:en_rd_before", en_rd_o, 1);
    check("mid:addr_before", addr_rd_o, 100);
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("mid:held_en_wr", en_wr_o, 0);
    end
    RST = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      check("mid:rel_busy", busy_o, 0);
      check("mid:rel_en_rd", en_rd_o, 0);
      check("mid:rel_en_wr", en_wr_o, 0);
      check("mid:rel_done", done_o, 0);
    end

    // a fresh edge after reset launches a full run again
    start_i = 1'b0;
    repeat (2) @(negedge CLK);
    do_run("after_reset", 1'b0);
    done_handshake("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
